serial_cmd_initiator: RTL and testbench

//  Host-side command initiator for the board serial command protocol: sends opcode + 0..4 argument

---
 rtl/serial_cmd_initiator.sv | 135 +++++++++++++
 tb/tb_serial_cmd_initiator.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_initiator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : serial_cmd_initiator
// Brief    : Sends opcode + 0..4 argument bytes through a UART transmitter, then
//            collects a fixed number of response bytes with an inter-byte timeout.
// Revision : 1.0
//------------------------------------------------------------------------------
module serial_cmd_initiator #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [7:0]   cmd_opcode,
    input  logic [31:0]  cmd_args,
    input  logic [2:0]   cmd_nargs,
    input  logic [5:0]   cmd_nresp,
    input  logic         txBusy,
    output logic         txStart,
    output logic [7:0]   txData,
    input  logic         rxReady,
    input  logic [7:0]   rxData,
    output logic [255:0] resp_data,
    output logic [5:0]   resp_count,
    output logic         done,
    output logic         timeout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TX_LOAD = 3'd1;
    localparam logic [2:0] S_TX_GAP  = 3'd2;
    localparam logic [2:0] S_RX      = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    logic [2:0]   r_state;
    logic [39:0]  r_tx_shift;
    logic [2:0]   r_tx_left;
    logic [5:0]   r_nresp;
    logic [31:0]  r_wait_cnt;
    logic         r_timed_out;
    logic [5:0]   r_resp_count;
    logic [255:0] r_resp_data;

    logic         w_accept;
    logic         w_send;
    logic [2:0]   w_nargs_clamped;
    logic [5:0]   w_nresp_clamped;
    logic [31:0]  w_wait_next;
    logic [5:0]   w_count_next;

    assign w_nargs_clamped = (cmd_nargs > 3'd4) ? 3'd4 : cmd_nargs;
    assign w_nresp_clamped = (cmd_nresp > 6'd32) ? 6'd32 : cmd_nresp;
    assign w_wait_next     = r_wait_cnt + 32'd1;
    assign w_count_next    = r_resp_count + 6'd1;

    assign cmd_ready  = (r_state == S_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_send     = (r_state == S_TX_LOAD) && !txBusy;
    assign txStart    = w_send;
    assign txData     = w_send ? r_tx_shift[7:0] : 8'h00;
    assign done       = (r_state == S_FINISH);
    assign timeout    = done && r_timed_out;
    assign resp_data  = r_resp_data;
    assign resp_count = r_resp_count;

    // Bytes go out LSB-first from a shift register holding {args, opcode}.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tx_shift   <= '0;
            r_tx_left    <= '0;
            r_nresp      <= '0;
            r_wait_cnt   <= '0;
            r_timed_out  <= 1'b0;
            r_resp_count <= '0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tx_shift   <= {cmd_args, cmd_opcode};
                        r_tx_left    <= 3'd1 + w_nargs_clamped;
                        r_nresp      <= w_nresp_clamped;
                        r_resp_data  <= '0;
                        r_resp_count <= '0;
                        r_timed_out  <= 1'b0;
                        r_state      <= S_TX_LOAD;
                    end
                end
                S_TX_LOAD: begin
                    if (w_send) begin
                        r_tx_shift <= {8'h00, r_tx_shift[39:8]};
                        r_tx_left  <= r_tx_left - 3'd1;
                        r_state    <= S_TX_GAP;
                    end
                end
                S_TX_GAP: begin
                    if (r_tx_left != 3'd0) begin
                        r_state <= S_TX_LOAD;
                    end else if (r_nresp == 6'd0) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_wait_cnt <= '0;
                        r_state    <= S_RX;
                    end
                end
                S_RX: begin
                    // A byte arriving on the timeout cycle takes priority.
                    if (rxReady) begin
                        r_resp_data[{r_resp_count[4:0], 3'b000} +: 8] <= rxData;
                        r_resp_count <= w_count_next;
                        r_wait_cnt   <= '0;
                        if (w_count_next == r_nresp) begin
                            r_state <= S_FINISH;
                        end
                    end else if (w_wait_next >= TIMEOUT_CYCLES - 32'd1) begin
                        r_timed_out <= 1'b1;
                        r_state     <= S_FINISH;
                    end else begin
                        r_wait_cnt <= w_wait_next;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_cmd_initiator.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : tb_serial_cmd_initiator
// Brief    : Scoreboard bench with a UART busy model and a randomized responder.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_serial_cmd_initiator;

    localparam int TIMEOUT = 100;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_opcode;
    logic [31:0]  cmd_args;
    logic [2:0]   cmd_nargs;
    logic [5:0]   cmd_nresp;
    logic         txBusy;
    logic         txStart;
    logic [7:0]   txData;
    logic         rxReady;
    logic [7:0]   rxData;
    logic [255:0] resp_data;
    logic [5:0]   resp_count;
    logic         done;
    logic         timeout;

    always #5 clk = ~clk;

    serial_cmd_initiator #(.TIMEOUT_CYCLES(32'd100)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_args   (cmd_args),
        .cmd_nargs  (cmd_nargs),
        .cmd_nresp  (cmd_nresp),
        .txBusy     (txBusy),
        .txStart    (txStart),
        .txData     (txData),
        .rxReady    (rxReady),
        .rxData     (rxData),
        .resp_data  (resp_data),
        .resp_count (resp_count),
        .done       (done),
        .timeout    (timeout)
    );

    typedef struct {
        logic [5:0]   count;
        logic [255:0] data;
        logic         to;
    } resp_t;

    logic [7:0] exp_tx[$];
    resp_t      exp_done[$];
    resp_t      mon_e;
    logic [7:0] rx_bytes [64];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tx_seen = 0;
    int done_seen = 0;
    int last_tx_cyc = 0;
    int last_done_cyc = 0;
    int busy_len = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // UART transmitter: busy from the cycle after txStart for busy_len cycles.
    initial begin
        txBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (txStart && !txBusy) begin
                @(posedge clk);
                #1 txBusy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 txBusy = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a byte or a completion.
    initial begin
        forever begin
            @(negedge clk);
            if (txStart) begin
                check("tx_while_busy", 256'(txBusy), 256'(0));
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: got byte %0h expected no txStart", txData);
                end else begin
                    check("tx_byte", 256'(txData), 256'(exp_tx.pop_front()));
                end
                tx_seen++;
                last_tx_cyc = cyc;
            end
            if (done) begin
                done_seen++;
                last_done_cyc = cyc;
                if (exp_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: got done expected none");
                end else begin
                    mon_e = exp_done.pop_front();
                    check("resp_count", 256'(resp_count), 256'(mon_e.count));
                    check("resp_data", resp_data, mon_e.data);
                    check("timeout_flag", 256'(timeout), 256'(mon_e.to));
                end
            end else if (timeout) begin
                checks++;
                failures++;
                $display("FAIL timeout_alone: got timeout=1 expected 0 without done");
            end
        end
    end

    task automatic check_reset_values();
        check("rst_cmd_ready", 256'(cmd_ready), 256'(1));
        check("rst_txStart", 256'(txStart), 256'(0));
        check("rst_txData", 256'(txData), 256'(0));
        check("rst_resp_data", resp_data, 256'(0));
        check("rst_resp_count", 256'(resp_count), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_timeout", 256'(timeout), 256'(0));
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] args,
                         input logic [2:0] na, input logic [5:0] nr);
        int t;
        t = 0;
        while (!cmd_ready && t < 2000) begin
            step();
            t++;
        end
        check("cmd_ready_wait", 256'(cmd_ready), 256'(1));
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_args   = args;
        cmd_nargs  = na;
        cmd_nresp  = nr;
        step();
    endtask

    // k = number of response bytes the downstream board returns (from rx_bytes).
    task automatic run_cmd(input logic [7:0] op, input logic [31:0] args,
                           input logic [2:0] na, input logic [5:0] nr, input int k);
        resp_t e;
        int na_e, nr_e, n_st, target_tx, base_done, rx_start, st_last, due, t;
        na_e = (na > 3'd4) ? 4 : int'(na);
        nr_e = (nr > 6'd32) ? 32 : int'(nr);
        n_st = (k < nr_e) ? k : nr_e;
        exp_tx.push_back(op);
        for (int i = 0; i < na_e; i++) exp_tx.push_back(args[8*i +: 8]);
        e.count = 6'(n_st);
        e.data  = '0;
        for (int i = 0; i < n_st; i++) e.data[8*i +: 8] = rx_bytes[i];
        e.to = (k < nr_e);
        exp_done.push_back(e);
        target_tx = tx_seen + 1 + na_e;
        base_done = done_seen;

        issue(op, args, na, nr);
        // Busy cycle: a competing request and a stray received byte must both be ignored.
        cmd_opcode = 8'hFF;
        cmd_nargs  = 3'd4;
        cmd_nresp  = 6'd32;
        rxReady    = 1'b1;
        rxData     = 8'h5A;
        step();
        cmd_valid = 1'b0;
        rxReady   = 1'b0;

        t = 0;
        while (tx_seen < target_tx && t < 2000) begin
            step();
            t++;
        end
        check("tx_count_wait", 256'(tx_seen >= target_tx), 256'(1));

        rx_start = cyc;
        st_last  = cyc;
        if (nr_e > 0) begin
            step();
            rx_start = cyc;
            for (int i = 0; i < k; i++) begin
                rxReady = 1'b1;
                rxData  = rx_bytes[i];
                if (i == n_st - 1) st_last = cyc;
                step();
                rxReady = 1'b0;
                repeat (int'($urandom_range(0, 4))) step();
            end
        end

        if (nr_e == 0)      due = last_tx_cyc + 2;
        else if (k < nr_e)  due = ((n_st == 0) ? rx_start - 1 : st_last) + TIMEOUT;
        else                due = st_last + 1;

        t = 0;
        while (done_seen == base_done && t < 500) begin
            step();
            t++;
        end
        check("done_wait", 256'(done_seen != base_done), 256'(1));
        if (done_seen != base_done) check("done_cycle", 256'(last_done_cyc), 256'(due));
        check("hold_resp_count", 256'(resp_count), 256'(e.count));
        check("hold_resp_data", resp_data, e.data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr_e, k;
        logic [5:0] nr;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_args   = '0;
        cmd_nargs  = '0;
        cmd_nresp  = '0;
        rxReady    = 1'b0;
        rxData     = '0;
        repeat (3) step();
        check_reset_values();
        reset = 1'b0;
        step();

        busy_len = 2;
        rx_bytes[0] = 8'h06;
        run_cmd(8'h00, 32'h0, 3'd0, 6'd1, 1);
        run_cmd(8'h01, 32'h14, 3'd1, 6'd0, 0);
        busy_len = 10;
        run_cmd(8'h06, 32'hDEADBEEF, 3'd4, 6'd0, 0);
        busy_len = 1;
        for (int i = 0; i < 33; i++) rx_bytes[i] = 8'(i);
        run_cmd(8'h0A, 32'h0, 3'd0, 6'd32, 33);
        rx_bytes[0] = 8'hA1;
        rx_bytes[1] = 8'hB2;
        run_cmd(8'h07, 32'h0, 3'd0, 6'd4, 2);

        // Reset while the third byte is being transmitted.
        busy_len = 10;
        exp_tx.push_back(8'h33);
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        exp_tx.push_back(8'h33);
        exp_tx.push_back(8'h44);
        k = tx_seen + 3;
        issue(8'h33, 32'h44332211, 3'd4, 6'd8);
        cmd_valid = 1'b0;
        for (int t = 0; t < 200 && tx_seen < k; t++) step();
        check("rst_tx3_wait", 256'(tx_seen >= k), 256'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_tx.delete();
        check_reset_values();
        repeat (15) step();
        busy_len = 1;
        rx_bytes[0] = 8'h77;
        run_cmd(8'h02, 32'h0000_0055, 3'd1, 6'd1, 1);

        for (int n = 0; n < 24; n++) begin
            busy_len = int'($urandom_range(1, 3));
            nr = 6'($urandom_range(0, 40));
            nr_e = (nr > 6'd32) ? 32 : int'(nr);
            if (nr_e == 0)                k = 0;
            else if ($urandom_range(0, 3) == 0) k = int'($urandom_range(0, nr_e - 1));
            else if ($urandom_range(0, 2) == 0) k = nr_e + int'($urandom_range(1, 2));
            else                          k = nr_e;
            for (int i = 0; i < k; i++) rx_bytes[i] = 8'($urandom);
            run_cmd(8'($urandom), $urandom, 3'($urandom_range(0, 7)), nr, k);
        end

        repeat (5) step();
        check("tx_queue_drained", 256'(exp_tx.size()), 256'(0));
        check("done_queue_drained", 256'(exp_done.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
